// File: rtl/lc4_rf_pkg.sv
// Shared types and sizing helpers for the LC4 register-file write-port slice.
package lc4_rf_pkg;
  localparam int LC4_NUM_REGS  = 8;
  localparam int LC4_REG_IDX_W = 3;

  typedef logic [LC4_REG_IDX_W-1:0] reg_idx_t;
  typedef logic [LC4_NUM_REGS-1:0]  busy_vec_t;

  // Round-robin pointer width for 2..4 requesters.
  function automatic int ptr_w(input int nreq);
    return (nreq > 2) ? 2 : 1;
  endfunction
endpackage

// File: rtl/lc4_rr_arbiter.sv
// Combinational round-robin arbiter: first valid requester at or after ptr wins.
module lc4_rr_arbiter
  import lc4_rf_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic [NREQ-1:0]         req,
  input  logic [ptr_w(NREQ)-1:0]  ptr,
  input  logic                    en,
  output logic [NREQ-1:0]         gnt,
  output logic [ptr_w(NREQ)-1:0]  gnt_idx
);
  localparam int unsigned N  = NREQ;
  localparam int unsigned PW = ptr_w(NREQ);

  logic found;

  // Two passes: indices >= ptr first, then wrap around to the rest.
  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    found   = 1'b0;
    if (en) begin
      for (int unsigned k = 0; k < N; k++) begin
        if (!found && req[k] && (k >= 32'(ptr))) begin
          gnt[k]  = 1'b1;
          gnt_idx = PW'(k);
          found   = 1'b1;
        end
      end
      for (int unsigned k = 0; k < N; k++) begin
        if (!found && req[k]) begin
          gnt[k]  = 1'b1;
          gnt_idx = PW'(k);
          found   = 1'b1;
        end
      end
    end
  end
endmodule

// File: rtl/lc4_rf_wport_arbiter.sv
// Shares the LC4 regfile write port among NREQ sources and tracks pending
// destinations in a busy scoreboard (claim sets, commit clears).
module lc4_rf_wport_arbiter
  import lc4_rf_pkg::*;
#(
  parameter int n    = 16,
  parameter int NREQ = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 gwe,
  input  logic [NREQ-1:0]      i_req_valid,
  input  logic [3*NREQ-1:0]    i_req_rd,
  input  logic [n*NREQ-1:0]    i_req_data,
  output logic [NREQ-1:0]      o_req_ready,
  output reg_idx_t             o_rd,
  output logic [n-1:0]         o_wdata,
  output logic                 o_rd_we,
  input  logic                 i_claim_valid,
  input  reg_idx_t             i_claim_rd,
  output logic                 o_claim_ready,
  input  reg_idx_t             i_rs,
  input  reg_idx_t             i_rt,
  output logic                 o_rs_busy,
  output logic                 o_rt_busy,
  output busy_vec_t            o_busy
);
  localparam int PW = ptr_w(NREQ);

  logic [PW-1:0]   ptr;
  logic [NREQ-1:0] gnt;
  logic [PW-1:0]   gnt_idx;
  logic            xfer;
  reg_idx_t        sel_rd;
  logic [n-1:0]    sel_data;
  busy_vec_t       busy;
  busy_vec_t       busy_next;
  logic            claim_accept;

  lc4_rr_arbiter #(.NREQ(NREQ)) u_arb (
    .req     (i_req_valid),
    .ptr     (ptr),
    .en      (gwe & rst_n),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign o_req_ready = gnt;
  assign xfer        = |gnt;

  always_comb begin
    sel_rd   = '0;
    sel_data = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (gnt[k]) begin
        sel_rd   = sel_rd   | i_req_rd[3*k +: 3];
        sel_data = sel_data | i_req_data[n*k +: n];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr     <= '0;
      o_rd_we <= 1'b0;
      o_rd    <= '0;
      o_wdata <= '0;
    end else if (gwe) begin
      o_rd_we <= xfer;
      if (xfer) begin
        o_rd    <= sel_rd;
        o_wdata <= sel_data;
        ptr     <= (gnt_idx == PW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
      end
    end
  end

  assign o_claim_ready = gwe & rst_n & ~busy[i_claim_rd];
  assign claim_accept  = i_claim_valid & o_claim_ready;

  // Commit clear is applied before the claim set so a same-edge claim wins.
  always_comb begin
    busy_next = busy;
    if (o_rd_we)      busy_next[o_rd]       = 1'b0;
    if (claim_accept) busy_next[i_claim_rd] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   busy <= '0;
    else if (gwe) busy <= busy_next;
  end

  assign o_busy    = busy;
  assign o_rs_busy = busy[i_rs];
  assign o_rt_busy = busy[i_rt];
endmodule
